i2s_receiver: RTL



---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_input_sync.sv | 42 ++++
 rtl/i2s_receiver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding, default frame geometry
// and channel encoding common to the I2S sender and receiver.
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 24;
    localparam int unsigned I2S_SLOT_WIDTH = 32;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC,
        SKIP,
        SHIFT,
        PAD
    } i2s_state_t;

endpackage

// File: rtl/i2s_input_sync.sv
// Brings bclk/lrclk/sdata into the clk domain through 2-FF synchronisers and
// flags bclk rises; lrclk/sdata come out aligned to the same stage as the rise.
module i2s_input_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bclk,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_rise,
    output logic o_lrclk,
    output logic o_sdata
);

    logic r_bclk_meta, r_bclk_sync, r_bclk_dly;
    logic r_lr_meta, r_lr_sync;
    logic r_sd_meta, r_sd_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_dly  <= 1'b0;
            r_lr_meta   <= 1'b0;
            r_lr_sync   <= 1'b0;
            r_sd_meta   <= 1'b0;
            r_sd_sync   <= 1'b0;
        end else begin
            r_bclk_meta <= i_bclk;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_dly  <= r_bclk_sync;
            r_lr_meta   <= i_lrclk;
            r_lr_sync   <= r_lr_meta;
            r_sd_meta   <= i_sdata;
            r_sd_sync   <= r_sd_meta;
        end
    end

    assign o_rise  = r_bclk_sync && !r_bclk_dly;
    assign o_lrclk = r_lr_sync;
    assign o_sdata = r_sd_sync;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: deserialises MSB-first, one-bit-delayed I2S slots into
// left/right pairs on a valid/ready port, with framing/overflow/link-loss flags.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = I2S_DATA_WIDTH,
    parameter int unsigned SLOT_WIDTH     = I2S_SLOT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_err,
    output logic                  overflow,
    output logic                  link_lost
);

    localparam int unsigned CNT_W = $clog2(SLOT_WIDTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic w_rise, w_lrclk, w_sdata;

    i2s_input_sync u_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_bclk  (bclk),
        .i_lrclk (lrclk),
        .i_sdata (sdata),
        .o_rise  (w_rise),
        .o_lrclk (w_lrclk),
        .o_sdata (w_sdata)
    );

    i2s_state_t            r_state, w_state_nxt;
    logic                  r_chan, w_chan_nxt;
    logic                  r_lr_prev;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_left_hold, r_right_hold;
    logic                  r_have_left, r_pair;
    logic [DATA_WIDTH-1:0] r_out_left, r_out_right;
    logic                  r_out_valid, r_frame_err, r_overflow;
    logic [TO_W-1:0]       r_tcnt;
    logic                  r_link_lost;

    logic                  w_lr_edge, w_timeout_hit;
    logic                  w_cnt_clr, w_shift_en, w_word_done, w_frame_err, w_drop;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_lr_edge     = w_rise && (w_lrclk != r_lr_prev);
    assign w_timeout_hit = !w_rise && (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_word        = {r_shift, w_sdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
            r_chan  <= LEFT;
        end else begin
            r_state <= w_state_nxt;
            r_chan  <= w_chan_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_word_done = 1'b0;
        w_frame_err = 1'b0;
        w_drop      = 1'b0;
        if (w_timeout_hit) begin
            w_state_nxt = SYNC;
            w_drop      = 1'b1;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_lr_edge) begin
                        w_state_nxt = SKIP;
                        w_chan_nxt  = w_lrclk;
                    end
                end
                // The rise that exposed the lrclk edge carries the delay bit;
                // SKIP drops it and hands over before the next rise arrives.
                SKIP: begin
                    w_state_nxt = SHIFT;
                    w_cnt_clr   = 1'b1;
                end
                SHIFT: begin
                    if (w_lr_edge) begin
                        w_frame_err = 1'b1;
                        w_drop      = 1'b1;
                        w_state_nxt = SKIP;
                        w_chan_nxt  = w_lrclk;
                    end else if (w_rise) begin
                        w_shift_en = 1'b1;
                        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            w_word_done = 1'b1;
                            w_state_nxt = PAD;
                        end
                    end
                end
                PAD: begin
                    if (w_lr_edge) begin
                        w_state_nxt = SKIP;
                        w_chan_nxt  = w_lrclk;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lr_prev    <= 1'b0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_have_left  <= 1'b0;
            r_pair       <= 1'b0;
            r_out_left   <= '0;
            r_out_right  <= '0;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_tcnt       <= '0;
            r_link_lost  <= 1'b0;
        end else begin
            if (w_rise) begin
                r_lr_prev <= w_lrclk;
            end

            if (w_cnt_clr || w_drop) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_word[DATA_WIDTH-2:0];
                r_cnt   <= r_cnt + CNT_W'(1);
            end

            r_pair <= 1'b0;
            if (w_drop) begin
                r_have_left <= 1'b0;
            end
            if (w_word_done) begin
                if (r_chan == LEFT) begin
                    r_left_hold <= w_word;
                    r_have_left <= 1'b1;
                end else if (r_have_left) begin
                    r_right_hold <= w_word;
                    r_pair       <= 1'b1;
                    r_have_left  <= 1'b0;
                end
            end

            // A pending pair loads whenever the slot is free or being drained now.
            if (r_pair && (!r_out_valid || out_ready)) begin
                r_out_left  <= r_left_hold;
                r_out_right <= r_right_hold;
                r_out_valid <= 1'b1;
            end else begin
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (r_pair) begin
                    r_overflow <= 1'b1;
                end
            end

            r_frame_err <= w_frame_err;

            if (w_rise) begin
                r_tcnt      <= '0;
                r_link_lost <= 1'b0;
            end else if (r_tcnt != TO_W'(TIMEOUT_CYCLES)) begin
                r_tcnt <= r_tcnt + TO_W'(1);
                if (w_timeout_hit) begin
                    r_link_lost <= 1'b1;
                end
            end
        end
    end

    assign out_left  = r_out_left;
    assign out_right = r_out_right;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign link_lost = r_link_lost;

endmodule
